// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: state encoding, destination codes and beat sizing
// shared by the main-memory bus responder.
package mem_bus_pkg;
    localparam int MAX_BEATS = 4;
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    localparam logic [1:0] DEST_IC = 2'b01;
    localparam logic [1:0] DEST_DC = 2'b10;
    typedef enum logic [2:0] {
        S_IDLE, S_HDR_ACK, S_WR_DATA, S_ACCESS, S_RD_REQ, S_RD_XFER, S_WAIT_ACK
    } state_t;
endpackage

// File: rtl/mem_bus_controller_mem_array.sv
// mem_array: single-port synchronous word RAM, one-cycle registered read.
module mem_array #(
    parameter int WORDS = 16384
) (
    input  logic        clk,
    input  logic        we,
    input  logic [13:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) r_mem[addr] <= wdata;
        rdata <= r_mem[addr];
    end
endmodule

// File: rtl/mem_bus_controller.sv
// mem_bus_controller: memory end of the system bus; stores write bursts and
// returns read bursts by becoming bus master through BR/BG.
module mem_bus_controller
    import mem_bus_pkg::*;
#(
    parameter int MEM_WORDS  = 16384,
    parameter int ACCESS_LAT = 4
) (
    input  logic        BUS_CLK,
    input  logic        RST,
    input  logic        DEST_IN,
    input  logic [1:0]  SRC_IN,
    input  logic [15:0] A_IN,
    input  logic [11:0] SIZE_IN,
    input  logic        RW_IN,
    input  logic [31:0] D_IN,
    output logic        ACK_OUT,
    output logic        BR,
    input  logic        BG,
    input  logic        ACK_IN,
    output logic        BUS_OE,
    output logic [15:0] A_OUT,
    output logic [11:0] SIZE_OUT,
    output logic        RW_OUT,
    output logic [31:0] D_OUT,
    output logic [1:0]  DEST_OUT,
    output logic        BUSY,
    output logic        ERR
);
    localparam int ACC_MAX = ACCESS_LAT > MAX_BEATS ? ACCESS_LAT : MAX_BEATS;
    localparam int CNT_W = $clog2(ACC_MAX) + 1;
    localparam int IDX_W = $clog2(MAX_BEATS);

    state_t            r_state, w_next;
    logic [15:0]       r_addr;
    logic [11:0]       r_size;
    logic              r_rw;
    logic [1:0]        r_src;
    logic [BEAT_W-1:0] r_beats;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next, w_acc_len;
    logic [31:0]       r_buf [MAX_BEATS];
    logic              r_ack, r_err;
    logic [9:0]        w_req_beats;
    logic              w_legal, w_cnt_last, w_acc_done, w_in_beats, w_we;
    logic [IDX_W-1:0]  w_idx;
    logic [13:0]       w_ram_addr;
    logic [31:0]       w_rdata;

    assign w_req_beats = SIZE_IN[11:2];
    assign w_legal     = SIZE_IN[1:0] == 2'b00 && w_req_beats != 10'd0 && w_req_beats <= 10'(MAX_BEATS);
    assign w_idx       = r_cnt[IDX_W-1:0];
    assign w_in_beats  = r_cnt < CNT_W'(r_beats);
    assign w_cnt_last  = r_cnt == CNT_W'(r_beats) - 1'b1;
    // ACCESS must also cover every beat when the latency is shorter than the burst
    assign w_acc_len   = CNT_W'(ACCESS_LAT) > CNT_W'(r_beats) ? CNT_W'(ACCESS_LAT) : CNT_W'(r_beats);
    assign w_acc_done  = r_cnt == w_acc_len - 1'b1;
    assign w_we        = r_state == S_ACCESS && r_rw && w_in_beats;
    // Reads prefetch word 0 in HDR_ACK so ACCESS cycle c sees word c on rdata
    assign w_ram_addr  = r_addr[15:2] + (r_state == S_ACCESS ? 14'(r_cnt) + 14'(!r_rw) : 14'd0);

    mem_array #(.WORDS(MEM_WORDS)) u_array (
        .clk   (BUS_CLK),
        .we    (w_we),
        .addr  (w_ram_addr),
        .wdata (r_buf[w_idx]),
        .rdata (w_rdata)
    );

    always_ff @(posedge BUS_CLK) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_ack   <= (r_state == S_IDLE && DEST_IN && w_legal) || (r_state == S_ACCESS && r_rw && w_acc_done);
            if (r_state == S_IDLE && DEST_IN && !w_legal) r_err <= 1'b1;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (r_state == S_IDLE && DEST_IN) begin
            r_addr  <= A_IN;
            r_size  <= SIZE_IN;
            r_rw    <= RW_IN;
            r_src   <= SRC_IN;
            r_beats <= SIZE_IN[BEAT_W+1:2];
        end
        if (r_state == S_WR_DATA) r_buf[w_idx] <= D_IN;
        if (r_state == S_ACCESS && !r_rw && w_in_beats) r_buf[w_idx] <= w_rdata;
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE:     if (DEST_IN && w_legal) w_next = S_HDR_ACK;
            S_HDR_ACK: begin
                w_next     = r_rw ? S_WR_DATA : S_ACCESS;
                w_cnt_next = '0;
            end
            S_WR_DATA: begin
                w_cnt_next = w_cnt_last ? '0 : r_cnt + 1'b1;
                if (w_cnt_last) w_next = S_ACCESS;
            end
            S_ACCESS: begin
                w_cnt_next = w_acc_done ? '0 : r_cnt + 1'b1;
                if (w_acc_done) w_next = r_rw ? S_IDLE : S_RD_REQ;
            end
            S_RD_REQ:   if (BG) w_next = S_RD_XFER;
            S_RD_XFER: begin
                w_cnt_next = w_cnt_last ? '0 : r_cnt + 1'b1;
                if (w_cnt_last) w_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: if (ACK_IN) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    assign ACK_OUT  = r_ack;
    assign BUS_OE   = r_state == S_RD_XFER;
    assign BR       = r_state == S_RD_REQ || r_state == S_RD_XFER;
    assign A_OUT    = BUS_OE ? r_addr : '0;
    assign SIZE_OUT = BUS_OE ? r_size : '0;
    assign RW_OUT   = 1'b0;
    assign D_OUT    = BUS_OE ? r_buf[w_idx] : '0;
    assign DEST_OUT = BUS_OE ? r_src : '0;
    assign BUSY     = r_state != S_IDLE;
    assign ERR      = r_err;
endmodule
